// File: rtl/ifetch_unit_if.sv
// ============================================================================
//  Module   : ifetch_unit_if
//  Brief    : Fetch-unit bus bundle: decode-side control, imem port, decode output.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface ifetch_unit_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_already;
    logic [31:0] pc;

    modport master (
        input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, ir, ir_already, pc
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, ir, ir_already, pc
    );
endinterface

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ============================================================================
//  Module   : ifetch_unit
//  Brief    : Instruction fetch with one-entry skid buffer and redirect drain.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;

    state_t      r_state,      w_state_nxt;
    logic [31:0] r_fetch_pc,   w_fetch_pc_nxt;
    logic [31:0] r_ir,         w_ir_nxt;
    logic [31:0] r_pc,         w_pc_nxt;
    logic        r_ir_already, w_ir_already_nxt;
    logic [31:0] r_buf_ir,     w_buf_ir_nxt;
    logic [31:0] r_buf_pc,     w_buf_pc_nxt;
    logic [31:0] r_target,     w_target_nxt;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_inc;
    logic        w_imem_req;

    assign w_redirect_pc = bus.redirect_pc & c_WORD_MASK;
    assign w_pc_inc      = r_fetch_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_BOOT;
            r_fetch_pc   <= RESET_PC;
            r_ir         <= 32'd0;
            r_pc         <= 32'd0;
            r_ir_already <= 1'b0;
            r_buf_ir     <= 32'd0;
            r_buf_pc     <= 32'd0;
            r_target     <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_ir         <= w_ir_nxt;
            r_pc         <= w_pc_nxt;
            r_ir_already <= w_ir_already_nxt;
            r_buf_ir     <= w_buf_ir_nxt;
            r_buf_pc     <= w_buf_pc_nxt;
            r_target     <= w_target_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_ir_nxt         = r_ir;
        w_pc_nxt         = r_pc;
        w_ir_already_nxt = 1'b0;
        w_buf_ir_nxt     = r_buf_ir;
        w_buf_pc_nxt     = r_buf_pc;
        w_target_nxt     = r_target;
        w_imem_req       = 1'b0;

        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.redirect) begin
                    if (bus.imem_ack) begin
                        w_fetch_pc_nxt = w_redirect_pc;
                    end else begin
                        // The bus cannot retract a request, so wait out the old one.
                        w_target_nxt = w_redirect_pc;
                        w_state_nxt  = S_DRAIN;
                    end
                end else if (bus.imem_ack) begin
                    w_fetch_pc_nxt = w_pc_inc;
                    if (bus.stall) begin
                        w_buf_ir_nxt = bus.imem_rdata;
                        w_buf_pc_nxt = r_fetch_pc;
                        w_state_nxt  = S_FULL;
                    end else begin
                        w_ir_nxt         = bus.imem_rdata;
                        w_pc_nxt         = r_fetch_pc;
                        w_ir_already_nxt = 1'b1;
                    end
                end
            end
            S_FULL: begin
                if (bus.redirect) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                    w_state_nxt    = S_FETCH;
                end else if (!bus.stall) begin
                    w_ir_nxt         = r_buf_ir;
                    w_pc_nxt         = r_buf_pc;
                    w_ir_already_nxt = 1'b1;
                    w_state_nxt      = S_FETCH;
                end
            end
            S_DRAIN: begin
                w_imem_req = 1'b1;
                if (bus.imem_ack) begin
                    w_fetch_pc_nxt = bus.redirect ? w_redirect_pc : r_target;
                    w_state_nxt    = S_FETCH;
                end else if (bus.redirect) begin
                    w_target_nxt = w_redirect_pc;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    // Reset gates the request combinationally so an in-flight access is dropped at once.
    assign bus.imem_req   = w_imem_req & ~reset;
    assign bus.imem_addr  = r_fetch_pc;
    assign bus.ir         = r_ir;
    assign bus.pc         = r_pc;
    assign bus.ir_already = r_ir_already;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
//  Module   : tb_ifetch_unit
//  Brief    : Self-checking scoreboard bench for ifetch_unit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ifetch_unit;

    localparam logic [31:0] c_K = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        r_ack_en;
    logic        r_force_ack;
    int          r_n_vec;
    int          r_n_err;
    logic [31:0] r_q_pc[$];

    ifetch_unit_if bus ();

    ifetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        r_n_vec++;
        if (act !== exp) begin
            r_n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Memory responds within the cycle; outputs are sampled 1 ns after the edge.
    task automatic cyc();
        logic [31:0] w_exp;
        #1;
        bus.imem_ack   = r_force_ack | (r_ack_en & bus.imem_req);
        bus.imem_rdata = bus.imem_addr ^ c_K;
        @(posedge clk);
        #1;
        if (bus.ir_already) begin
            if (r_q_pc.size() == 0) begin
                check("unexp_pulse", {31'd0, bus.ir_already}, 32'd0);
            end else begin
                w_exp = r_q_pc.pop_front();
                check("deliv_pc", bus.pc, w_exp);
                check("deliv_ir", bus.ir, w_exp ^ c_K);
            end
        end
    endtask

    initial begin
        r_n_vec         = 0;
        r_n_err         = 0;
        r_ack_en        = 1'b1;
        r_force_ack     = 1'b0;
        reset           = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'd0;

        // Reset and boot
        cyc();
        cyc();
        check("rst_ir", bus.ir, 32'd0);
        check("rst_pc", bus.pc, 32'd0);
        check("rst_pulse", {31'd0, bus.ir_already}, 32'd0);
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        reset = 1'b0;
        #1;
        check("boot_req", {31'd0, bus.imem_req}, 32'd0);
        cyc();
        check("first_req", {31'd0, bus.imem_req}, 32'd1);
        check("first_addr", bus.imem_addr, 32'h0);

        // Streaming then stall on 0x8
        r_q_pc.push_back(32'h0);
        cyc();
        check("pulse0", {31'd0, bus.ir_already}, 32'd1);
        r_q_pc.push_back(32'h4);
        cyc();
        check("pulse4", {31'd0, bus.ir_already}, 32'd1);
        bus.stall = 1'b1;
        cyc();
        check("full_req", {31'd0, bus.imem_req}, 32'd0);
        check("full_pulse", {31'd0, bus.ir_already}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("stall_req", {31'd0, bus.imem_req}, 32'd0);
            check("stall_pulse", {31'd0, bus.ir_already}, 32'd0);
        end
        bus.stall = 1'b0;
        r_q_pc.push_back(32'h8);
        cyc();
        check("unstall_pulse", {31'd0, bus.ir_already}, 32'd1);
        check("resume_req", {31'd0, bus.imem_req}, 32'd1);
        check("resume_addr", bus.imem_addr, 32'hC);

        // Redirect while a request is outstanding
        r_q_pc.push_back(32'hC);
        cyc();
        r_ack_en = 1'b0;
        cyc();
        check("pend_addr", bus.imem_addr, 32'h10);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h103;
        cyc();
        bus.redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("drain_req", {31'd0, bus.imem_req}, 32'd1);
            check("drain_addr", bus.imem_addr, 32'h10);
            check("drain_pulse", {31'd0, bus.ir_already}, 32'd0);
        end
        r_ack_en = 1'b1;
        cyc();
        check("drop_pulse", {31'd0, bus.ir_already}, 32'd0);
        check("redir_addr", bus.imem_addr, 32'h100);

        // Redirect while holding a buffered instruction
        bus.stall = 1'b1;
        cyc();
        check("full2_req", {31'd0, bus.imem_req}, 32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        cyc();
        bus.redirect = 1'b0;
        bus.stall    = 1'b0;
        check("flush_pulse", {31'd0, bus.ir_already}, 32'd0);
        check("flush_addr", bus.imem_addr, 32'h40);
        r_q_pc.push_back(32'h40);
        cyc();

        // Redirect coinciding with ack, then address wrap
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFE;
        cyc();
        bus.redirect = 1'b0;
        check("ackredir_pulse", {31'd0, bus.ir_already}, 32'd0);
        check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        r_q_pc.push_back(32'hFFFF_FFFC);
        cyc();
        r_q_pc.push_back(32'h0);
        cyc();
        check("post_wrap_addr", bus.imem_addr, 32'h4);

        // A second redirect during drain replaces the target
        r_ack_en        = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        cyc();
        bus.redirect_pc = 32'h300;
        cyc();
        bus.redirect = 1'b0;
        check("drain2_addr", bus.imem_addr, 32'h4);
        r_ack_en = 1'b1;
        cyc();
        check("retarget_addr", bus.imem_addr, 32'h300);
        r_q_pc.push_back(32'h300);
        cyc();

        // Reset in the middle of a drain, with a late ack after it
        r_ack_en        = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h500;
        cyc();
        bus.redirect = 1'b0;
        reset        = 1'b1;
        cyc();
        check("mid_rst_ir", bus.ir, 32'd0);
        check("mid_rst_pc", bus.pc, 32'd0);
        check("mid_rst_pulse", {31'd0, bus.ir_already}, 32'd0);
        check("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
        reset       = 1'b0;
        r_force_ack = 1'b1;
        #1;
        check("late_ack_req", {31'd0, bus.imem_req}, 32'd0);
        cyc();
        r_force_ack = 1'b0;
        check("restart_addr", bus.imem_addr, 32'h0);
        check("restart_req", {31'd0, bus.imem_req}, 32'd1);
        check("restart_pulse", {31'd0, bus.ir_already}, 32'd0);
        r_ack_en = 1'b1;
        r_q_pc.push_back(32'h0);
        cyc();
        check("restart_next", bus.imem_addr, 32'h4);
        check("sb_empty", r_q_pc.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", r_n_vec, r_n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  downstream cannot accept a new instruction this cycle.
REQ-005 redirect  input  1  control-flow change (branch/jump/flush) requested this cycle.
REQ-006 redirect_pc  input  32  target address; valid while redirect=1.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  word address of the request; bits [1:0] always 0.
REQ-009 imem_ack  input  1  read complete; imem_rdata valid this cycle; may assert in the same cycle as imem_req.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 ir  output  32  instruction delivered to decode.
REQ-012 ir_already  output  1  one-cycle pulse: ir/pc hold a new instruction to be sampled by decode.
REQ-013 pc  output  32  address of the instruction on ir.

Function
REQ-014 The internal fetch_pc register SHALL drive imem_addr, and imem_addr SHALL not change while imem_req=1 and imem_ack=0.
REQ-015 The FSM SHALL have the states S_BOOT, S_FETCH, S_FULL and S_DRAIN.
REQ-016 S_BOOT: imem_req=0; next state S_FETCH unconditionally.
REQ-017 S_FETCH: imem_req=1.
- ack, redirect=0, stall=0: ir<=imem_rdata, pc<=fetch_pc, ir_already<=1, fetch_pc<=fetch_pc+4; stay.
- ack, redirect=0, stall=1: buffer<=(imem_rdata, fetch_pc), fetch_pc<=fetch_pc+4; go to S_FULL.
- ack, redirect=1: discard the data, fetch_pc<=redirect_pc; stay.
- no ack, redirect=1: target<=redirect_pc; go to S_DRAIN.
REQ-018 S_FULL: imem_req=0.
- redirect=1: discard the buffer, fetch_pc<=redirect_pc; go to S_FETCH.
- stall=0: ir/pc<=buffer, ir_already<=1; go to S_FETCH.
- stall=1: hold.
REQ-019 S_DRAIN: imem_req=1 with the unchanged address; a further redirect overwrites target; on ack discard the data, fetch_pc<=target (or redirect_pc if redirect=1 that cycle); go to S_FETCH.
REQ-020 Redirect SHALL take priority over stall and over delivery; ir_already SHALL be 0 in the cycle after any redirect.
REQ-021 redirect_pc[1:0] SHALL be forced to 0 when loaded.
REQ-022 fetch_pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 ir_already SHALL be 1 only in the single cycle after a delivery; otherwise 0. ir and pc SHALL hold their last delivered values.
REQ-024 Latency: ack in cycle N with stall=0 and redirect=0 -> ir_already=1 in cycle N+1. Back-to-back single-cycle acks SHALL give one instruction per cycle.
REQ-025 At most one instruction SHALL be buffered. No request SHALL be issued while in S_FULL.

Reset
REQ-026 With reset=1 at a clock edge, the block SHALL go to:
- state S_BOOT
- fetch_pc=RESET_PC
- ir=0, pc=0, ir_already=0
- buffer empty, target=0
REQ-027 During reset, imem_req SHALL be 0.
REQ-028 Reset mid-operation SHALL abandon any outstanding request without waiting for ack; a late ack SHALL be ignored in S_BOOT.

Verification
REQ-029 Reset, then ack every cycle with rdata=addr^32'hA5A5_0000, stall=0 -> first imem_req in the 2nd cycle after reset; pc=0,4,8,... on consecutive cycles with ir_already=1 each cycle.
REQ-030 stall=1 when the instruction at 0x8 is acked -> imem_req=0 while stalled; 3 cycles later stall=0 -> one ir_already pulse with pc=0x8; next request at 0xC.
REQ-031 Request at 0x10 pending with no ack, redirect=1 to 0x103 -> imem_addr stays 0x10 until ack; that data is dropped; next request at 0x100; ir_already=0 throughout the drain.
REQ-032 Redirect to 0x40 in S_FULL with stall=1 -> buffered instruction never delivered; next request at 0x40.
REQ-033 Redirect to 0xFFFF_FFFC, ack each cycle -> pc=0xFFFF_FFFC delivered, then pc=0x0000_0000.
REQ-034 reset=1 while in S_DRAIN -> next cycle all outputs match REQ-026; fetch restarts at RESET_PC.
